store_buffer: RTL and testbench

- Committed-store queue directly downstream of the MEM stage's store path.
- The WB stage pushes a store when a store instruction carrying `sotre_buffer_we` commits without exception.
- The buffer drains entries in order to the data cache / uncached bridge over a req/addr_ok/data_ok handshake.
- It reports full, empty and load-address conflicts so MEM/WB can stall loads and uncached accesses.

---
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Committed-store queue between WB and the data cache / uncached bridge.
// In-order drain over a req/addr_ok/data_ok handshake, with a load word-address conflict check.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic [31:0] push_paddr_i,
    input  logic [31:0] push_wdata_i,
    input  logic [3:0]  push_wstrb_i,
    input  logic        push_uncache_i,
    output logic        sb_allowin_o,
    output logic        sb_empty_o,
    input  logic [31:0] ld_paddr_i,
    input  logic        ld_check_i,
    output logic        ld_conflict_o,
    output logic        wr_req_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_wdata_o,
    output logic [3:0]  wr_wstrb_o,
    output logic        wr_uncache_o,
    input  logic        wr_addr_ok_i,
    input  logic        wr_data_ok_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      paddr_q   [DEPTH];
    logic [31:0]      wdata_q   [DEPTH];
    logic [3:0]       wstrb_q   [DEPTH];
    logic             uncache_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] hit;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    state_t           state_q;
    state_t           state_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Full comes from the registered count only, so a same-cycle pop never frees a slot.
    assign full         = (count_q == FULL_CNT);
    assign do_push      = push_i & ~full;
    assign sb_allowin_o = ~full;
    assign sb_empty_o   = (count_q == '0) & (state_q == S_IDLE);

    assign wr_addr_o    = paddr_q[head_q];
    assign wr_wdata_o   = wdata_q[head_q];
    assign wr_wstrb_o   = wstrb_q[head_q];
    assign wr_uncache_o = uncache_q[head_q];

    always_comb begin
        state_d  = state_q;
        wr_req_o = 1'b0;
        do_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_REQ;
            end
            S_REQ: begin
                wr_req_o = 1'b1;
                if (wr_addr_ok_i) begin
                    if (wr_data_ok_i) begin
                        do_pop  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wr_data_ok_i) begin
                    do_pop  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (do_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            paddr_q[tail_q]   <= push_paddr_i;
            wdata_q[tail_q]   <= push_wdata_i;
            wstrb_q[tail_q]   <= push_wstrb_i;
            uncache_q[tail_q] <= push_uncache_i;
        end
    end

    // Word-granular match: the low two address bits are masked out, strobes ignored.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        assign hit[g] = valid_q[g] &
                        (((paddr_q[g] ^ ld_paddr_i) & 32'hFFFF_FFFC) == 32'h0);
    end

    assign ld_conflict_o = ld_check_i & (|hit);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_i;
    logic [31:0] push_paddr_i;
    logic [31:0] push_wdata_i;
    logic [3:0]  push_wstrb_i;
    logic        push_uncache_i;
    logic        sb_allowin_o;
    logic        sb_empty_o;
    logic [31:0] ld_paddr_i;
    logic        ld_check_i;
    logic        ld_conflict_o;
    logic        wr_req_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_wdata_o;
    logic [3:0]  wr_wstrb_o;
    logic        wr_uncache_o;
    logic        wr_addr_ok_i;
    logic        wr_data_ok_i;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_i         (push_i),
        .push_paddr_i   (push_paddr_i),
        .push_wdata_i   (push_wdata_i),
        .push_wstrb_i   (push_wstrb_i),
        .push_uncache_i (push_uncache_i),
        .sb_allowin_o   (sb_allowin_o),
        .sb_empty_o     (sb_empty_o),
        .ld_paddr_i     (ld_paddr_i),
        .ld_check_i     (ld_check_i),
        .ld_conflict_o  (ld_conflict_o),
        .wr_req_o       (wr_req_o),
        .wr_addr_o      (wr_addr_o),
        .wr_wdata_o     (wr_wdata_o),
        .wr_wstrb_o     (wr_wstrb_o),
        .wr_uncache_o   (wr_uncache_o),
        .wr_addr_ok_i   (wr_addr_ok_i),
        .wr_data_ok_i   (wr_data_ok_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        unc;
    } store_t;

    // Reference: the committed stores still owed to memory, oldest first, plus
    // whether the oldest one is currently offered or already accepted downstream.
    store_t sq[$];
    bit     offered;
    bit     accepted;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit exp_conf;
        exp_conf = 1'b0;
        foreach (sq[i])
            if (sq[i].addr[31:2] == ld_paddr_i[31:2]) exp_conf = 1'b1;
        check_eq("allowin", 32'(sb_allowin_o), 32'(sq.size() < DEPTH));
        check_eq("empty", 32'(sb_empty_o), 32'(sq.size() == 0 && !offered && !accepted));
        check_eq("req", 32'(wr_req_o), 32'(offered));
        check_eq("conflict", 32'(ld_conflict_o), 32'(ld_check_i & exp_conf));
        if (offered && sq.size() > 0) begin
            check_eq("wr_addr", wr_addr_o, sq[0].addr);
            check_eq("wr_wdata", wr_wdata_o, sq[0].data);
            check_eq("wr_wstrb", 32'(wr_wstrb_o), 32'(sq[0].strb));
            check_eq("wr_uncache", 32'(wr_uncache_o), 32'(sq[0].unc));
        end
    endtask

    task automatic update_model();
        bit     room;
        bit     start;
        bit     done;
        store_t e;
        if (rst_n) begin
            sq.delete();
            offered  = 1'b0;
            accepted = 1'b0;
            return;
        end
        room  = sq.size() < DEPTH;
        start = !offered && !accepted && sq.size() > 0;
        done  = (offered && wr_addr_ok_i && wr_data_ok_i) || (accepted && wr_data_ok_i);
        if (offered && wr_addr_ok_i) begin
            offered  = 1'b0;
            accepted = !wr_data_ok_i;
        end else if (accepted && wr_data_ok_i) begin
            accepted = 1'b0;
        end else if (start) begin
            offered = 1'b1;
        end
        if (done) void'(sq.pop_front());
        if (push_i && room) begin
            e.addr = push_paddr_i;
            e.data = push_wdata_i;
            e.strb = push_wstrb_i;
            e.unc  = push_uncache_i;
            sq.push_back(e);
        end
    endtask

    // Inputs are set at posedge+1; outputs compared mid-cycle; model advances at the edge.
    task automatic step();
        @(negedge clk);
        #1;
        compare_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle_inputs();
        rst_n          = 1'b0;
        push_i         = 1'b0;
        push_paddr_i   = 32'h0;
        push_wdata_i   = 32'h0;
        push_wstrb_i   = 4'h0;
        push_uncache_i = 1'b0;
        ld_paddr_i     = 32'h0;
        ld_check_i     = 1'b0;
        wr_addr_ok_i   = 1'b0;
        wr_data_ok_i   = 1'b0;
    endtask

    task automatic set_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        push_i         = 1'b1;
        push_paddr_i   = a;
        push_wdata_i   = d;
        push_wstrb_i   = s;
        push_uncache_i = a[4];
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1;
        step();
        step();
        rst_n = 1'b0;
        check_eq("rst_allowin", 32'(sb_allowin_o), 32'd1);
        check_eq("rst_empty", 32'(sb_empty_o), 32'd1);
        check_eq("rst_req", 32'(wr_req_o), 32'd0);

        // Single store through the full handshake.
        set_push(32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
        step();
        push_i = 1'b0;
        check_eq("single_not_empty", 32'(sb_empty_o), 32'd0);
        step();
        check_eq("single_req", 32'(wr_req_o), 32'd1);
        check_eq("single_addr", wr_addr_o, 32'h1000_0004);
        step();
        check_eq("single_req_held", 32'(wr_req_o), 32'd1);
        wr_addr_ok_i = 1'b1;
        step();
        wr_addr_ok_i = 1'b0;
        check_eq("single_wait_req", 32'(wr_req_o), 32'd0);
        step();
        wr_data_ok_i = 1'b1;
        step();
        wr_data_ok_i = 1'b0;
        check_eq("single_empty", 32'(sb_empty_o), 32'd1);

        // Fill to full with addr_ok held low, then a refused 5th push.
        for (int i = 0; i < 5; i++) begin
            set_push(32'h3000_0000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'(i + 1));
            step();
        end
        check_eq("full_allowin", 32'(sb_allowin_o), 32'd0);
        // Pop and push in the same cycle while full: push refused.
        set_push(32'h3000_0040, 32'hAAAA_5555, 4'h3);
        wr_addr_ok_i = 1'b1;
        wr_data_ok_i = 1'b1;
        step();
        wr_addr_ok_i = 1'b0;
        wr_data_ok_i = 1'b0;
        check_eq("pop_push_allowin", 32'(sb_allowin_o), 32'd1);
        step();
        push_i = 1'b0;
        check_eq("after_push_full", 32'(sb_allowin_o), 32'd0);
        wr_addr_ok_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            wr_data_ok_i = 1'($urandom_range(0, 1));
            step();
        end
        wr_addr_ok_i = 1'b0;
        wr_data_ok_i = 1'b0;
        check_eq("drained_empty", 32'(sb_empty_o), 32'd1);

        // Load conflict on a buffered word, then after it pops.
        set_push(32'h2000_0008, 32'h0BAD_F00D, 4'h1);
        step();
        push_i     = 1'b0;
        ld_check_i = 1'b1;
        ld_paddr_i = 32'h2000_000B;
        #1;
        check_eq("conf_hit", 32'(ld_conflict_o), 32'd1);
        ld_paddr_i = 32'h2000_000C;
        #1;
        check_eq("conf_miss", 32'(ld_conflict_o), 32'd0);
        ld_paddr_i = 32'h2000_000B;
        wr_addr_ok_i = 1'b1;
        wr_data_ok_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        wr_addr_ok_i = 1'b0;
        wr_data_ok_i = 1'b0;
        check_eq("conf_after_pop", 32'(ld_conflict_o), 32'd0);
        ld_check_i = 1'b0;

        // Reset while waiting for data_ok with two entries, then a stray data_ok.
        set_push(32'h4000_0000, 32'h1234_5678, 4'hF);
        step();
        set_push(32'h4000_0010, 32'h8765_4321, 4'hC);
        step();
        push_i = 1'b0;
        wr_addr_ok_i = 1'b1;
        step();
        wr_addr_ok_i = 1'b0;
        check_eq("wait_req_low", 32'(wr_req_o), 32'd0);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        check_eq("midrst_empty", 32'(sb_empty_o), 32'd1);
        wr_data_ok_i = 1'b1;
        step();
        wr_data_ok_i = 1'b0;
        check_eq("stray_empty", 32'(sb_empty_o), 32'd1);
        check_eq("stray_allowin", 32'(sb_allowin_o), 32'd1);

        // Random traffic over a small address pool so conflicts and wrap-around are frequent.
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 299) == 0);
            push_i         = ($urandom_range(0, 99) < 45);
            push_paddr_i   = 32'h2000_0000 | 32'($urandom_range(0, 31));
            push_wdata_i   = $urandom;
            push_wstrb_i   = 4'($urandom_range(1, 15));
            push_uncache_i = 1'($urandom_range(0, 1));
            ld_paddr_i     = 32'h2000_0000 | 32'($urandom_range(0, 31));
            ld_check_i     = 1'($urandom_range(0, 1));
            wr_addr_ok_i   = ($urandom_range(0, 99) < 40);
            wr_data_ok_i   = ($urandom_range(0, 99) < 40);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
